// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with a valid/ready request port and a SWEEP mode
// that walks the one-hot bit from a start index up to the top index.
module dec_onehot_seq #(
    parameter int ENC_W     = 5,
    parameter bit MASK_ZERO = 1'b1,
    parameter bit SWEEP_EN  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ENC_W-1:0]          enc,
    input  logic                      mode,
    input  logic                      abort,
    output logic [(1 << ENC_W)-1:0]   dec,
    output logic                      dec_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int DEC_W = 2 ** ENC_W;
    localparam logic [ENC_W-1:0] TOP_IDX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ENC_W-1:0]   cnt_q, cnt_d;
    logic [DEC_W-1:0]   dec_q, dec_d;
    logic               dec_valid_q, dec_valid_d;
    logic               done_q, done_d;

    logic [ENC_W-1:0]   dec_idx;
    logic [ENC_W-1:0]   cnt_inc;
    logic [DEC_W-1:0]   onehot;
    logic               accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    // Index 0 is the hard-wired zero register when masked: it never gets an enable.
    generate
        for (genvar gi = 0; gi < DEC_W; gi++) begin : g_dec
            if (MASK_ZERO && gi == 0) begin : g_masked
                assign onehot[gi] = 1'b0;
            end else begin : g_bit
                assign onehot[gi] = (dec_idx == ENC_W'(gi));
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_valid_d = 1'b0;
        done_d      = 1'b0;
        dec_idx     = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dec_valid_d = 1'b1;
                    dec_idx     = enc;
                    if (SWEEP_EN && mode) begin
                        cnt_d = enc;
                        if (enc == TOP_IDX) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = SWEEP;
                        end
                    end
                end
            end
            SWEEP: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d       = cnt_inc;
                    dec_idx     = cnt_inc;
                    dec_valid_d = 1'b1;
                    if (cnt_inc == TOP_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        dec_d = dec_valid_d ? onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
            done_q      <= done_d;
        end
    end

    assign dec       = dec_q;
    assign dec_valid = dec_valid_q;
    assign done      = done_q;
    assign busy      = (state_q == SWEEP);

endmodule

// File: doc/dec_onehot_seq.md
Name: dec_onehot_seq

Overview:
- Registered, parametrised successor to the combinational 5-to-32 one-hot decoder.
- Primary use: producing register-file write-enable vectors.
- Adds a valid/ready input handshake, a registered output with valid, optional masking of index 0 (hard-wired zero register), and a SWEEP mode that walks one-hot from a start index to the top index, one per cycle (bulk register clear/init).

Parameters:
- ENC_W, 5, encoded index width. Decoded width DEC_W = 2**ENC_W is a derived localparam, not overridable.
- MASK_ZERO, 1, when 1 index 0 decodes to all-zeros (dec_valid still asserted); when 0 index 0 decodes to bit 0.
- SWEEP_EN, 1, when 0 the mode input is ignored and all accepted requests are SINGLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- enc  input  ENC_W  index (SINGLE) or start index (SWEEP)
- mode  input  1  0 = SINGLE, 1 = SWEEP
- abort  input  1  terminate an active sweep
- dec  output  DEC_W  registered one-hot output
- dec_valid  output  1  dec is meaningful this cycle
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse on the last sweep output or on abort

Behaviour:
- Reset (rst_n=0 at a rising edge): dec=0, dec_valid=0, busy=0, done=0, state=IDLE, counter=0. Reset has priority over every other input, including mid-sweep.
- Accept condition: in_valid & in_ready at a rising edge. in_ready = (state==IDLE); it is combinational from state only, never from in_valid.
- States: IDLE, SWEEP.
- IDLE, accepted with mode=0 (or SWEEP_EN=0):
  - Next cycle dec = 1<<enc (zero if MASK_ZERO and enc==0), dec_valid=1.
  - State stays IDLE, so back-to-back SINGLE requests are accepted every cycle and produce one output per cycle.
  - Latency 1 cycle.
- IDLE, no accept: next cycle dec=0, dec_valid=0, done=0.
- IDLE, accepted with mode=1 and SWEEP_EN=1:
  - counter=enc; next cycle dec = 1<<enc (masked rule applies), dec_valid=1.
  - If enc==DEC_W-1, done=1 that same output cycle and state stays IDLE (single-step sweep, busy never asserted).
  - Otherwise state goes to SWEEP, busy=1.
- SWEEP, each cycle without abort:
  - counter increments; dec = 1<<counter, dec_valid=1.
  - When counter reaches DEC_W-1: done=1 in that output cycle, busy=0, state returns to IDLE.
  - No wrap-around past DEC_W-1.
- SWEEP with abort=1 at an edge: next cycle dec=0, dec_valid=0, done=1, busy=0, state returns to IDLE. abort is ignored in IDLE.
- in_valid during SWEEP: not accepted (in_ready=0). The requester must hold it; it is accepted on the first IDLE cycle.
- Output is strictly one-hot or all-zero at every cycle. Never more than one bit set.
- busy is registered and equals (state==SWEEP).
- enc is sampled only on accept; changes at other times have no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, enc=5'd7 -> dec=0, dec_valid=0, busy=0, done=0, in_ready=1 after release, no output generated.
- SINGLE back-to-back, MASK_ZERO=1: enc=3,31,0 on consecutive cycles -> dec=32'h0000_0008, 32'h8000_0000, 32'h0000_0000, with dec_valid=1 on all three cycles, each 1 cycle after accept.
- SINGLE, MASK_ZERO=0: enc=0 -> dec=32'h0000_0001.
- SWEEP from 28: mode=1, enc=28 -> dec=32'h1000_0000, 2000_0000, 4000_0000, 8000_0000 on 4 consecutive cycles; busy=1 for the first 3; done=1 with 32'h8000_0000; in_ready=0 for 3 cycles, then 1.
- SWEEP abort: start at enc=1, assert abort on the 3rd output cycle -> following cycle dec=0, dec_valid=0, done=1, busy=0; a pending in_valid (mode=0, enc=4) is accepted that cycle and yields 32'h0000_0010 one cycle later.
- Mid-sweep reset: start sweep at enc=0, assert rst_n=0 on the 5th output cycle -> next cycle all outputs 0, state IDLE, no done pulse.
